// File: rtl/write_back_scoreboard_if.sv
// write_back_scoreboard_if
//   Bundles the ID-stage hazard query and the scoreboard's stall response.
//   Ports (signals):
//     id_valid, id_rs_1, id_rs_2, id_uses_rs_1, id_uses_rs_2,
//     id_rd, id_reg_write, id_mem_read, ex_flush    : ID stage -> scoreboard
//     stall, hazard_rs_1, hazard_rs_2, stall_count   : scoreboard -> pipeline
//   Modports: master (pipeline side), slave (scoreboard side).
interface write_back_scoreboard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic [4:0]       id_rs_1;
    logic [4:0]       id_rs_2;
    logic             id_uses_rs_1;
    logic             id_uses_rs_2;
    logic [4:0]       id_rd;
    logic             id_reg_write;
    logic             id_mem_read;
    logic             ex_flush;
    logic             stall;
    logic             hazard_rs_1;
    logic             hazard_rs_2;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_valid, id_rs_1, id_rs_2, id_uses_rs_1, id_uses_rs_2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        input  stall, hazard_rs_1, hazard_rs_2, stall_count
    );

    modport slave (
        input  id_valid, id_rs_1, id_rs_2, id_uses_rs_1, id_uses_rs_2,
               id_rd, id_reg_write, id_mem_read, ex_flush,
        output stall, hazard_rs_1, hazard_rs_2, stall_count
    );
endinterface

// File: rtl/write_back_scoreboard.sv
// write_back_scoreboard
//   Tracks register writes in flight through EX, MEM and WB with a shadow
//   pipeline and stalls decode when a source operand cannot be forwarded yet.
//   Ports:
//     clk  : pipeline clock, rising edge
//     rst  : asynchronous active-low reset
//     bus  : write_back_scoreboard_if.slave (ID query in, stall/hazard/count out)
module write_back_scoreboard #(
    parameter int unsigned CNT_W = 16
) (
    input logic                    clk,
    input logic                    rst,
    write_back_scoreboard_if.slave bus
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } entry_t;

    entry_t s_ex_q, s_ex_d;
    entry_t s_mem_q;
    entry_t s_wb_q;

    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic             hazard_1, hazard_2, stall_int;

    // S_WB is kept for write-back visibility only; no hazard reads it.
    logic unused_wb;
    assign unused_wb = ^s_wb_q;

    // Youngest entry decides: an EX match always stalls; a MEM match only
    // stalls for loads, whose data forwards from WB one cycle later.
    function automatic logic src_hazard(input logic [4:0] rs, input logic uses,
                                        input logic id_valid, input entry_t ex,
                                        input entry_t mem);
        logic hz;
        hz = 1'b0;
        if (id_valid && uses && (rs != 5'd0)) begin
            if (ex.valid && ex.reg_write && (ex.rd == rs)) begin
                hz = 1'b1;
            end else if (mem.valid && mem.reg_write && mem.mem_read && (mem.rd == rs)) begin
                hz = 1'b1;
            end
        end
        return hz;
    endfunction

    always_comb begin
        hazard_1  = src_hazard(bus.id_rs_1, bus.id_uses_rs_1, bus.id_valid, s_ex_q, s_mem_q);
        hazard_2  = src_hazard(bus.id_rs_2, bus.id_uses_rs_2, bus.id_valid, s_ex_q, s_mem_q);
        // A flush kills the ID instruction, so there is nothing to hold.
        stall_int = (hazard_1 | hazard_2) & ~bus.ex_flush;
    end

    always_comb begin
        s_ex_d = '0;
        if (bus.id_valid && !stall_int && !bus.ex_flush) begin
            s_ex_d.valid     = 1'b1;
            s_ex_d.rd        = bus.id_rd;
            // x0 writes are architecturally dropped and never create a hazard.
            s_ex_d.reg_write = bus.id_reg_write && (bus.id_rd != 5'd0);
            s_ex_d.mem_read  = bus.id_mem_read;
        end
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall_int && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ex_q        <= '0;
            s_mem_q       <= '0;
            s_wb_q        <= '0;
            stall_count_q <= '0;
        end else begin
            s_ex_q        <= s_ex_d;
            s_mem_q       <= s_ex_q;
            s_wb_q        <= s_mem_q;
            stall_count_q <= stall_count_d;
        end
    end

    assign bus.stall       = stall_int;
    assign bus.hazard_rs_1 = hazard_1;
    assign bus.hazard_rs_2 = hazard_2;
    assign bus.stall_count = stall_count_q;

endmodule

// File: tb/tb_write_back_scoreboard.sv
// tb_write_back_scoreboard
//   Table-driven check of the scoreboard plus hand sequences for reset
//   mid-stall and counter saturation. A narrow counter keeps saturation short.
module tb_write_back_scoreboard;

    localparam int unsigned CNT_W = 8;

    typedef struct {
        logic       valid;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       rw;
        logic       mr;
        logic       flush;
        logic       e_stall;
        logic       e_h1;
        logic       e_h2;
    } vec_t;

    typedef struct {
        logic             s;
        logic             h1;
        logic             h2;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [CNT_W-1:0] exp_cnt;
    vec_t             tbl[$];
    exp_t             sb[$];

    write_back_scoreboard_if #(.CNT_W(CNT_W)) bus ();

    write_back_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic valid, logic [4:0] rs1, logic u1, logic [4:0] rs2,
                                logic u2, logic [4:0] rd, logic rw, logic mr, logic flush,
                                logic es, logic eh1, logic eh2);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.rw = rw; v.mr = mr; v.flush = flush;
        v.e_stall = es; v.e_h1 = eh1; v.e_h2 = eh2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic apply(input vec_t v);
        bus.id_valid     = v.valid;
        bus.id_rs_1      = v.rs1;
        bus.id_uses_rs_1 = v.u1;
        bus.id_rs_2      = v.rs2;
        bus.id_uses_rs_2 = v.u2;
        bus.id_rd        = v.rd;
        bus.id_reg_write = v.rw;
        bus.id_mem_read  = v.mr;
        bus.ex_flush     = v.flush;
    endtask

    // One pipeline cycle: drive at negedge, record expectation, sample mid-low-phase.
    task automatic run_cycle(input vec_t v, input string tag);
        exp_t e;
        @(negedge clk);
        apply(v);
        e.s = v.e_stall; e.h1 = v.e_h1; e.h2 = v.e_h2; e.cnt = exp_cnt;
        sb.push_back(e);
        #3;
        if (sb.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, " stall"}, {31'd0, bus.stall}, {31'd0, e.s});
            chk({tag, " hazard_rs_1"}, {31'd0, bus.hazard_rs_1}, {31'd0, e.h1});
            chk({tag, " hazard_rs_2"}, {31'd0, bus.hazard_rs_2}, {31'd0, e.h2});
            chk({tag, " stall_count"}, 32'(bus.stall_count), 32'(e.cnt));
            if (e.s && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            run_cycle(mk(0, 8, 1, 8, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("idle%0d", i));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_cnt = '0;
        rst     = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset state
        #12;
        chk("reset stall", {31'd0, bus.stall}, 32'd0);
        chk("reset hazard_rs_1", {31'd0, bus.hazard_rs_1}, 32'd0);
        chk("reset hazard_rs_2", {31'd0, bus.hazard_rs_2}, 32'd0);
        chk("reset stall_count", 32'(bus.stall_count), 32'd0);
        do_reset();

        // ALU producer x5 -> reader rs_1: one stall cycle
        tbl.push_back(mk(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 6, 1, 8, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 5, 1, 6, 1, 8, 1, 0, 0, 0, 0, 0));
        // Load x5 -> reader rs_2: two stall cycles
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 5, 1, 10, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 9, 1, 5, 1, 10, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 9, 1, 5, 1, 10, 1, 0, 0, 0, 0, 0));
        // Load x5, independent, reader: one stall cycle
        tbl.push_back(mk(1, 2, 1, 0, 0, 5, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 11, 1, 12, 1, 13, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 5, 1, 10, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(1, 9, 1, 5, 1, 10, 1, 0, 0, 0, 0, 0));
        // x0 writer/reader, and unused matching rs_1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 4, 0, 7, 1, 9, 1, 0, 0, 0, 0, 0));
        // Both sources hit the same entry: single stall
        tbl.push_back(mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 6, 1, 6, 1, 14, 1, 0, 0, 1, 1, 1));
        tbl.push_back(mk(1, 6, 1, 6, 1, 14, 1, 0, 0, 0, 0, 0));
        // Load x9 then ALU x9: youngest (ALU) decides
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 15, 1, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 9, 1, 0, 0, 15, 1, 0, 0, 0, 0, 0));
        // Load x7, reader flushed in its stall cycle; next S_EX must be a bubble
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 12, 1, 0, 1, 0, 1, 0));
        tbl.push_back(mk(1, 12, 1, 0, 0, 16, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], $sformatf("row%0d", i));
            // Drain between groups so each group starts from an empty shadow pipeline.
            if (i == 2 || i == 6 || i == 10 || i == 14 || i == 17 || i == 21 || i == 24) idle(3);
        end

        // Reset asserted during the first stall cycle of a load-use pair
        run_cycle(mk(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0, 0), "rst_load");
        run_cycle(mk(1, 3, 1, 0, 0, 17, 1, 0, 0, 1, 1, 0), "rst_reader");
        #1 rst = 1'b0;
        #1;
        chk("rst_mid stall", {31'd0, bus.stall}, 32'd0);
        chk("rst_mid hazard_rs_1", {31'd0, bus.hazard_rs_1}, 32'd0);
        chk("rst_mid stall_count", 32'(bus.stall_count), 32'd0);
        @(negedge clk);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2 rst = 1'b1;
        exp_cnt = '0;
        run_cycle(mk(1, 3, 1, 3, 1, 18, 1, 0, 0, 0, 0, 0), "post_rst_reader");

        // Saturation: self-dependent load to x1 stalls 2 of every 3 cycles
        do_reset();
        for (int k = 0; k < 3 * ((1 << CNT_W) + 5); k++) begin
            logic st;
            st = (k % 3) != 0;
            run_cycle(mk(1, 1, 1, 0, 0, 1, 1, 1, 0, st, st, 0), $sformatf("sat%0d", k));
        end
        #1;
        chk("sat final stall_count", 32'(bus.stall_count), 32'((1 << CNT_W) - 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
